// File: rtl/port_alloc_rr_seq.sv
// port_alloc_rr_seq: registered separable input-first switch allocator.
// Optional starvation override: define PA_STARVE_EN.
module port_alloc_rr_seq #(
    parameter int NUM_IN    = 5,
    parameter int NUM_OUT   = 5,
    parameter int STARVE_TH = 15,
    parameter int CNT_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN*NUM_OUT-1:0] req_vec,
    input  logic [NUM_IN-1:0]         req_tail,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_IN*NUM_OUT-1:0] alloc_vec,
    output logic [NUM_IN-1:0]         alloc_valid,
    output logic [NUM_OUT-1:0]        out_busy
);

    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    if (STARVE_TH > (1 << CNT_W) - 1) begin : g_cfg_bad
        $error("STARVE_TH exceeds wait counter range");
    end

    logic [IW-1:0]             owner   [NUM_OUT];
    logic [OW-1:0]             in_ptr  [NUM_IN];
    logic [IW-1:0]             out_ptr [NUM_OUT];

    logic [NUM_OUT-1:0]        req     [NUM_IN];
    logic [NUM_IN-1:0]         in_lock;
    logic [NUM_OUT-1:0]        lk_gnt;
    logic [NUM_OUT-1:0]        free;
    logic [NUM_IN-1:0]         s1_ok;
    logic [OW-1:0]             s1_sel  [NUM_IN];
    logic [NUM_IN-1:0]         prop    [NUM_OUT];
    logic [NUM_OUT-1:0]        s2_ok;
    logic [IW-1:0]             s2_win  [NUM_OUT];
    logic [NUM_IN*NUM_OUT-1:0] gnt;

`ifdef PA_STARVE_EN
    logic [CNT_W-1:0]          wcnt    [NUM_IN];
    logic [NUM_IN-1:0]         starve;
`endif

    // Unpack requests; find locked paths and outputs open to arbitration.
    always_comb begin
        in_lock = '0;
        lk_gnt  = '0;
        free    = '0;
        for (int i = 0; i < NUM_IN; i++)
            req[i] = req_vec[i*NUM_OUT +: NUM_OUT];
        for (int o = 0; o < NUM_OUT; o++) begin
            free[o] = out_ready[o] & ~out_busy[o];
            if (out_busy[o]) begin
                in_lock[owner[o]] = 1'b1;
                lk_gnt[o] = out_ready[o] & req[owner[o]][o];
            end
        end
    end

    // Stage 1: each input without a lock proposes one output.
    always_comb begin
        s1_ok = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            s1_sel[i] = '0;
            if (!in_lock[i]) begin
                for (int k = NUM_OUT-1; k >= 0; k--) begin
                    if (req[i][(int'(in_ptr[i]) + k) % NUM_OUT] &&
                        free[(int'(in_ptr[i]) + k) % NUM_OUT]) begin
                        s1_ok[i]  = 1'b1;
                        s1_sel[i] = OW'((int'(in_ptr[i]) + k) % NUM_OUT);
                    end
                end
`ifdef PA_STARVE_EN
                if (starve[i]) begin
                    for (int o = NUM_OUT-1; o >= 0; o--) begin
                        if (req[i][o] && free[o])
                            s1_sel[i] = OW'(o);
                    end
                end
`endif
            end
        end
    end

    // Stage 2: each free output accepts one proposer.
    always_comb begin
        s2_ok = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            s2_win[o] = '0;
            prop[o]   = '0;
            for (int i = 0; i < NUM_IN; i++)
                prop[o][i] = s1_ok[i] && (int'(s1_sel[i]) == o);
            for (int k = NUM_IN-1; k >= 0; k--) begin
                if (prop[o][(int'(out_ptr[o]) + k) % NUM_IN]) begin
                    s2_ok[o]  = 1'b1;
                    s2_win[o] = IW'((int'(out_ptr[o]) + k) % NUM_IN);
                end
            end
`ifdef PA_STARVE_EN
            for (int i = NUM_IN-1; i >= 0; i--) begin
                if (prop[o][i] && starve[i])
                    s2_win[o] = IW'(i);
            end
`endif
        end
    end

    // Merge locked-path and arbitrated grants.
    always_comb begin
        gnt = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if ((lk_gnt[o] && int'(owner[o]) == i) ||
                    (s2_ok[o] && int'(s2_win[o]) == i))
                    gnt[i*NUM_OUT + o] = 1'b1;
            end
        end
    end

    // Register grants; update pointers and packet locks.
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_vec   <= '0;
            alloc_valid <= '0;
            out_busy    <= '0;
            for (int o = 0; o < NUM_OUT; o++) begin
                owner[o]   <= '0;
                out_ptr[o] <= '0;
            end
            for (int i = 0; i < NUM_IN; i++)
                in_ptr[i] <= '0;
        end else begin
            alloc_vec <= gnt;
            for (int i = 0; i < NUM_IN; i++)
                alloc_valid[i] <= |gnt[i*NUM_OUT +: NUM_OUT];
            for (int o = 0; o < NUM_OUT; o++) begin
                if (lk_gnt[o]) begin
                    out_busy[o] <= ~req_tail[owner[o]];
                end else if (out_busy[o] && !req[owner[o]][o]) begin
                    out_busy[o] <= 1'b0;
                end else if (s2_ok[o]) begin
                    out_busy[o]        <= ~req_tail[s2_win[o]];
                    owner[o]           <= s2_win[o];
                    out_ptr[o]         <= IW'((int'(s2_win[o]) + 1) % NUM_IN);
                    in_ptr[s2_win[o]]  <= OW'((o + 1) % NUM_OUT);
                end
            end
        end
    end

`ifdef PA_STARVE_EN
    // Starving once the wait counter reaches the threshold.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++)
            starve[i] = int'(wcnt[i]) >= STARVE_TH;
    end

    // Saturating wait counters: count ungranted request cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++)
                wcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (|gnt[i*NUM_OUT +: NUM_OUT])
                    wcnt[i] <= '0;
                else if (|req[i] && wcnt[i] != {CNT_W{1'b1}})
                    wcnt[i] <= wcnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_port_alloc_rr_seq.sv
// tb_port_alloc_rr_seq: directed and random checks of the
// switch allocator against a behavioural reference model.
module tb_port_alloc_rr_seq;

    localparam int NI = 5;
    localparam int NO = 5;

    logic          clk;
    logic          reset;
    logic [24:0]   req_vec;
    logic [4:0]    req_tail;
    logic [4:0]    out_ready;
    logic [24:0]   alloc_vec;
    logic [4:0]    alloc_valid;
    logic [4:0]    out_busy;

    int total = 0;
    int bad   = 0;

    int m_owner [NO];
    int m_ip    [NI];
    int m_op    [NO];

    logic [24:0] exp_alloc;
    logic [4:0]  exp_valid;
    logic [4:0]  exp_busy;

    port_alloc_rr_seq #(
        .NUM_IN(NI),
        .NUM_OUT(NO),
        .STARVE_TH(15),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_vec(req_vec),
        .req_tail(req_tail),
        .out_ready(out_ready),
        .alloc_vec(alloc_vec),
        .alloc_valid(alloc_valid),
        .out_busy(out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] mk(input logic [4:0] a,
        input logic [4:0] b, input logic [4:0] c,
        input logic [4:0] d, input logic [4:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_owner[o] = -1;
            m_op[o] = 0;
        end
        for (int i = 0; i < NI; i++) m_ip[i] = 0;
        exp_alloc = '0;
        exp_valid = '0;
        exp_busy  = '0;
    endtask

    // One allocation cycle from the rules: packet owners keep their
    // output, everyone else bids round-robin for free ready outputs.
    task automatic model_step(input logic [24:0] rq,
                              input logic [4:0] tl,
                              input logic [4:0] rd);
        bit held [NI];
        int pick [NI];
        int win  [NO];
        int o, i, w;
        exp_alloc = '0;
        for (int n = 0; n < NI; n++) begin
            held[n] = 0;
            pick[n] = -1;
        end
        for (int n = 0; n < NO; n++) begin
            win[n] = -1;
            if (m_owner[n] >= 0) held[m_owner[n]] = 1;
        end
        for (int n = 0; n < NI; n++) begin
            if (held[n]) continue;
            for (int k = 0; k < NO; k++) begin
                o = (m_ip[n] + k) % NO;
                if (rq[n*NO+o] && rd[o] && m_owner[o] < 0) begin
                    pick[n] = o;
                    break;
                end
            end
        end
        for (int n = 0; n < NO; n++) begin
            if (m_owner[n] >= 0) begin
                w = m_owner[n];
                if (rq[w*NO+n] && rd[n]) exp_alloc[w*NO+n] = 1'b1;
                continue;
            end
            for (int k = 0; k < NI; k++) begin
                i = (m_op[n] + k) % NI;
                if (pick[i] == n) begin
                    win[n] = i;
                    exp_alloc[i*NO+n] = 1'b1;
                    break;
                end
            end
        end
        for (int n = 0; n < NO; n++) begin
            if (m_owner[n] >= 0) begin
                w = m_owner[n];
                if (!rq[w*NO+n]) m_owner[n] = -1;
                else if (rd[n] && tl[w]) m_owner[n] = -1;
            end else if (win[n] >= 0) begin
                m_op[n] = (win[n] + 1) % NI;
                m_ip[win[n]] = (n + 1) % NO;
                if (!tl[win[n]]) m_owner[n] = win[n];
            end
        end
        for (int n = 0; n < NI; n++)
            exp_valid[n] = |exp_alloc[n*NO +: NO];
        for (int n = 0; n < NO; n++)
            exp_busy[n] = (m_owner[n] >= 0);
    endtask

    task automatic cyc(input string tag, input logic rst,
                       input logic [24:0] rq, input logic [4:0] tl,
                       input logic [4:0] rd);
        @(negedge clk);
        reset     = rst;
        req_vec   = rq;
        req_tail  = tl;
        out_ready = rd;
        if (rst) model_reset();
        else model_step(rq, tl, rd);
        @(posedge clk);
        #1;
        chk({tag, ".alloc"}, 32'(alloc_vec), 32'(exp_alloc));
        chk({tag, ".valid"}, 32'(alloc_valid), 32'(exp_valid));
        chk({tag, ".busy"}, 32'(out_busy), 32'(exp_busy));
    endtask

    logic [24:0] rq;
    logic [4:0]  tl;
    logic [4:0]  rd;

    initial begin
        reset = 1'b1;
        req_vec = '0;
        req_tail = '0;
        out_ready = '0;
        model_reset();

        // reset and idle
        cyc("rst", 1'b1, '0, '0, '0);
        chk("rst.zero", 32'(alloc_vec), 32'd0);
        for (int n = 0; n < 5; n++)
            cyc("idle", 1'b0, '0, '0, 5'b11111);
        chk("idle.busy", 32'(out_busy), 32'd0);
        cyc("lk", 1'b0, mk(5'b00010, 0, 0, 0, 0), 5'b0, 5'b11111);
        chk("lk.busy", 32'(out_busy), 32'h2);
        cyc("midrst", 1'b1, mk(5'b00010, 0, 0, 0, 0), 5'b0, 5'b11111);
        chk("midrst.alloc", 32'(alloc_vec), 32'd0);
        chk("midrst.busy", 32'(out_busy), 32'd0);

        // rotation across two identical cycles
        cyc("rst2", 1'b1, '0, '0, '0);
        rq = mk(5'b00001, 5'b00001, 5'b01000, 5'b10000, 5'b00100);
        cyc("rr1", 1'b0, rq, 5'b11111, 5'b11111);
        chk("rr1.k", 32'(alloc_vec),
            32'(mk(5'b00001, 0, 5'b01000, 5'b10000, 5'b00100)));
        cyc("rr2", 1'b0, rq, 5'b11111, 5'b11111);
        chk("rr2.k", 32'(alloc_vec),
            32'(mk(0, 5'b00001, 5'b01000, 5'b10000, 5'b00100)));

        // multi-flit hold, release wins against a waiting input
        cyc("rst3", 1'b1, '0, '0, '0);
        rq = mk(5'b00010, 5'b00010, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            cyc("hold", 1'b0, rq, 5'b00010, 5'b11111);
            chk("hold.k", 32'(alloc_vec), 32'(mk(5'b00010, 0, 0, 0, 0)));
            chk("hold.b", 32'(out_busy), 32'h2);
        end
        cyc("tail", 1'b0, rq, 5'b00011, 5'b11111);
        chk("tail.k", 32'(alloc_vec), 32'(mk(5'b00010, 0, 0, 0, 0)));
        chk("tail.b", 32'(out_busy), 32'h0);
        cyc("next", 1'b0, mk(0, 5'b00010, 0, 0, 0), 5'b00010, 5'b11111);
        chk("next.k", 32'(alloc_vec), 32'(mk(0, 5'b00010, 0, 0, 0)));

        // locked output without credit
        cyc("rst4", 1'b1, '0, '0, '0);
        rq = mk(5'b00010, 0, 0, 0, 0);
        cyc("cr0", 1'b0, rq, 5'b0, 5'b11111);
        for (int n = 0; n < 2; n++) begin
            cyc("nocr", 1'b0, rq, 5'b0, 5'b11101);
            chk("nocr.k", 32'(alloc_vec), 32'd0);
            chk("nocr.b", 32'(out_busy), 32'h2);
        end
        cyc("cr1", 1'b0, rq, 5'b0, 5'b11111);
        chk("cr1.k", 32'(alloc_vec), 32'(mk(5'b00010, 0, 0, 0, 0)));

        // abort releases the lock
        cyc("rst5", 1'b1, '0, '0, '0);
        cyc("ab0", 1'b0, mk(5'b00100, 0, 0, 0, 0), 5'b0, 5'b11111);
        chk("ab0.b", 32'(out_busy), 32'h4);
        cyc("ab1", 1'b0, mk(0, 0, 0, 5'b00100, 0), 5'b01000, 5'b11111);
        chk("ab1.b", 32'(out_busy), 32'h0);
        cyc("ab2", 1'b0, mk(0, 0, 0, 5'b00100, 0), 5'b01000, 5'b11111);
        chk("ab2.k", 32'(alloc_vec), 32'(mk(0, 0, 0, 5'b00100, 0)));

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rq = '0;
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 1) == 1)
                    rq[i*NO +: NO] = 5'($urandom) | 5'($urandom);
            end
            for (int o = 0; o < NO; o++) begin
                if (m_owner[o] >= 0 && $urandom_range(0, 9) != 0)
                    rq[m_owner[o]*NO + o] = 1'b1;
            end
            for (int b = 0; b < 5; b++) begin
                tl[b] = ($urandom_range(0, 99) < 35);
                rd[b] = ($urandom_range(0, 99) < 85);
            end
            cyc("rnd", $urandom_range(0, 99) == 0, rq, tl, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
